// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
// pipeline_control : LC-3b stall/flush sequencer with redirect hold and
//                    stall/flush performance counters
// Rev 1.0
// ============================================================================
module pipeline_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble_enable,
  input  logic        icache_read,
  input  logic        icache_resp,
  input  logic        dcache_read,
  input  logic        dcache_write,
  input  logic        dcache_resp,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        pc_redirect,
  output logic [15:0] pc_target,
  output logic [15:0] dstall_count,
  output logic [15:0] istall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [0:0] {
    RUN           = 1'b0,
    REDIRECT_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] redirect_target_q, redirect_target_d;
  logic [15:0] dstall_q, dstall_d;
  logic [15:0] istall_q, istall_d;
  logic [15:0] flush_q, flush_d;

  logic d_stall;
  logic i_stall;

  assign d_stall = (dcache_read | dcache_write) & ~dcache_resp;
  assign i_stall = icache_read & ~icache_resp;

  assign dstall_count = dstall_q;
  assign istall_count = istall_q;
  assign flush_count  = flush_q;

  always_comb begin
    state_d           = state_q;
    redirect_target_d = redirect_target_q;
    dstall_d          = dstall_q;
    istall_d          = istall_q;
    flush_d           = flush_q;
    load_pc           = 1'b0;
    load_if_id        = 1'b0;
    load_id_ex        = 1'b0;
    load_ex_mem       = 1'b0;
    load_mem_wb       = 1'b0;
    flush_if_id       = 1'b0;
    flush_id_ex       = 1'b0;
    flush_ex_mem      = 1'b0;
    pc_redirect       = 1'b0;
    pc_target         = 16'h0000;

    if (!reset) begin
      if (d_stall) begin
        dstall_d = dstall_q + 16'd1;
      end

      unique case (state_q)
        RUN: begin
          pc_target = branch_target;
          // A D-cache stall freezes everything; MEM will re-present any branch.
          if (d_stall) begin
            load_pc = 1'b0;
          end else if (branch_taken) begin
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_d      = flush_q + 16'd1;
            if (i_stall) begin
              redirect_target_d = branch_target;
              state_d           = REDIRECT_WAIT;
            end else begin
              load_pc     = 1'b1;
              pc_redirect = 1'b1;
            end
          end else if (i_stall || bubble_enable) begin
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (i_stall) begin
              istall_d = istall_q + 16'd1;
            end
          end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
          end
        end

        REDIRECT_WAIT: begin
          pc_target = redirect_target_q;
          if (!d_stall) begin
            load_if_id  = 1'b1;
            flush_if_id = 1'b1;
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (branch_taken) begin
              redirect_target_d = branch_target;
              flush_d           = flush_q + 16'd1;
            end
          end
          // The PC side only waits on the fetch, not on the data cache.
          if (!i_stall) begin
            load_pc     = 1'b1;
            pc_redirect = 1'b1;
            state_d     = RUN;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= RUN;
      redirect_target_q <= 16'h0000;
      dstall_q          <= 16'h0000;
      istall_q          <= 16'h0000;
      flush_q           <= 16'h0000;
    end else begin
      state_q           <= state_d;
      redirect_target_q <= redirect_target_d;
      dstall_q          <= dstall_d;
      istall_q          <= istall_d;
      flush_q           <= flush_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
// tb_pipeline_control : directed stimulus, behavioural reference model and
//                       per-cycle comparison for pipeline_control
// Rev 1.0
// ============================================================================
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        bubble_enable, icache_read, icache_resp;
  logic        dcache_read, dcache_write, dcache_resp, branch_taken;
  logic [15:0] branch_target;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect;
  logic [15:0] pc_target, dstall_count, istall_count, flush_count;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  always #5 clk = ~clk;

  pipeline_control dut (
    .clk(clk), .reset(reset), .bubble_enable(bubble_enable),
    .icache_read(icache_read), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_resp(dcache_resp), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .dstall_count(dstall_count),
    .istall_count(istall_count), .flush_count(flush_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each stage is HOLD, ADVANCE or NOP-insert; a pending
  // redirect is a flag plus an address; counters are plain integers.
  localparam int HOLD = 0, ADV = 1, NOP = 2;
  bit          m_wait = 1'b0;
  logic [15:0] m_tgt  = 16'h0;
  int          m_d = 0, m_i = 0, m_f = 0;

  always @(negedge clk) begin
    if (!done) begin
      int          st[5];
      bit          ds, is, redir;
      logic [15:0] tgt;
      logic [4:0]  exp_ld;
      logic [2:0]  exp_fl;
      for (int k = 0; k < 5; k++) st[k] = HOLD;
      redir = 1'b0;
      tgt   = 16'h0;
      ds = (dcache_read || dcache_write) && !dcache_resp;
      is = icache_read && !icache_resp;

      if (!reset) begin
        if (!m_wait) begin
          if (ds) begin
            // frozen
          end else if (branch_taken) begin
            st[0] = is ? HOLD : ADV;
            st[1] = NOP; st[2] = NOP; st[3] = NOP; st[4] = ADV;
            if (!is) begin redir = 1'b1; tgt = branch_target; end
          end else if (is || bubble_enable) begin
            st[2] = NOP; st[3] = ADV; st[4] = ADV;
          end else begin
            for (int k = 0; k < 5; k++) st[k] = ADV;
          end
        end else begin
          if (!ds) begin st[1] = NOP; st[2] = NOP; st[3] = ADV; st[4] = ADV; end
          if (!is) begin st[0] = ADV; redir = 1'b1; tgt = m_tgt; end
        end
      end

      for (int k = 0; k < 5; k++) exp_ld[4-k] = (st[k] != HOLD);
      for (int k = 1; k < 4; k++) exp_fl[3-k] = (st[k] == NOP);

      chk("loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'(exp_ld));
      chk("flushes", {flush_if_id, flush_id_ex, flush_ex_mem}, 32'(exp_fl));
      chk("flush_without_load",
          {flush_if_id & ~load_if_id, flush_id_ex & ~load_id_ex, flush_ex_mem & ~load_ex_mem}, 32'd0);
      chk("pc_redirect", 32'(pc_redirect), 32'(redir));
      if (redir || reset) chk("pc_target", 32'(pc_target), 32'(tgt));
      if (!reset) begin
        chk("dstall_count", 32'(dstall_count), 32'(m_d % 65536));
        chk("istall_count", 32'(istall_count), 32'(m_i % 65536));
        chk("flush_count",  32'(flush_count),  32'(m_f % 65536));
      end

      // advance the model to what the coming edge produces
      if (reset) begin
        m_wait = 1'b0; m_tgt = 16'h0; m_d = 0; m_i = 0; m_f = 0;
      end else begin
        if (ds) m_d = (m_d + 1) % 65536;
        if (!m_wait) begin
          if (!ds && branch_taken) begin
            m_f = (m_f + 1) % 65536;
            if (is) begin m_wait = 1'b1; m_tgt = branch_target; end
          end else if (!ds && is) begin
            m_i = (m_i + 1) % 65536;
          end
        end else begin
          if (branch_taken && !ds) begin m_tgt = branch_target; m_f = (m_f + 1) % 65536; end
          if (!is) m_wait = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic bub, input logic ir, input logic irsp, input logic dr,
                       input logic dw, input logic drsp, input logic br, input logic [15:0] tgt);
    bubble_enable = bub; icache_read = ir; icache_resp = irsp;
    dcache_read = dr; dcache_write = dw; dcache_resp = drsp;
    branch_taken = br; branch_target = tgt;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    chk("rst_loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'd0);
    chk("rst_pc_target", 32'(pc_target), 32'h0);
    step(); step();
    reset = 1'b0;

    for (int n = 0; n < 10; n++) begin
      idle();
      chk("idle_loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h1F);
      step();
    end
    idle();
    chk("idle_counters", {dstall_count, istall_count}, 32'h0);
    chk("idle_flush_count", 32'(flush_count), 32'h0);

    // load-use bubble
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0);
    chk("bubble_ctl", {load_pc, load_if_id, load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}, 32'b001111);
    step();
    idle();
    chk("post_bubble_loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h1F);
    chk("bubble_istall", 32'(istall_count), 32'h0);
    step();

    // D-cache miss of four cycles
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0);
      chk("dstall_loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h0);
      step();
    end
    drive(0, 0, 0, 1, 0, 1, 0, 16'h0);
    chk("dresp_loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h1F);
    chk("dstall_4", 32'(dstall_count), 32'd4);
    step();

    // taken branch with I-cache idle
    drive(0, 0, 0, 0, 0, 0, 1, 16'h3000);
    chk("br_pc", {load_pc, pc_redirect}, 32'b11);
    chk("br_target", 32'(pc_target), 32'h3000);
    chk("br_flushes", {flush_if_id, flush_id_ex, flush_ex_mem}, 32'b111);
    step();
    idle();
    chk("br_flush_count", 32'(flush_count), 32'd1);
    chk("br_back_run", {pc_redirect, load_if_id, flush_if_id}, 32'b010);
    step();

    // taken branch during an outstanding fetch
    drive(0, 1, 0, 0, 0, 0, 1, 16'h1234);
    chk("brw_pc", {load_pc, pc_redirect}, 32'b00);
    step();
    for (int n = 0; n < 2; n++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
      chk("wait_nops", {load_pc, load_if_id, flush_if_id, load_id_ex, flush_id_ex}, 32'b01111);
      step();
    end
    drive(0, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("wait_resp_pc", {load_pc, pc_redirect}, 32'b11);
    chk("wait_resp_target", 32'(pc_target), 32'h1234);
    step();
    idle();
    chk("wait_done", {pc_redirect, 16'(flush_count)}, {1'b0, 16'd2});
    step();

    // same, with the D-cache stalling concurrently
    drive(0, 1, 0, 0, 0, 0, 1, 16'h2468);
    step();
    for (int n = 0; n < 2; n++) begin
      drive(0, 1, 0, 1, 0, 0, 0, 16'h0);
      chk("waitd_frozen", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h0);
      step();
    end
    drive(0, 1, 1, 1, 0, 0, 0, 16'h0);
    chk("waitd_resp_pc", {load_pc, pc_redirect, load_if_id}, 32'b110);
    chk("waitd_resp_target", 32'(pc_target), 32'h2468);
    step();
    drive(0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("waitd_run_frozen", {load_pc, pc_redirect}, 32'b00);
    step();
    drive(0, 0, 0, 1, 0, 1, 0, 16'h0);
    step();
    idle();
    chk("waitd_dstall", 32'(dstall_count), 32'd8);
    step();

    // newest redirect wins while waiting
    drive(0, 1, 0, 0, 0, 0, 1, 16'h1111);
    step();
    drive(0, 1, 0, 0, 0, 0, 1, 16'h2222);
    step();
    drive(0, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("newest_target", 32'(pc_target), 32'h2222);
    step();
    idle();
    chk("newest_flush_count", 32'(flush_count), 32'd5);
    step();

    // simultaneous D and I stall in RUN, then a plain I stall
    drive(0, 1, 0, 0, 1, 0, 0, 16'h0);
    chk("di_frozen", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h0);
    step();
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("di_istall_zero", 32'(istall_count), 32'd0);
    chk("istall_ctl", {load_pc, load_if_id, load_id_ex, flush_id_ex}, 32'b0011);
    step();
    idle();
    chk("istall_one", 32'(istall_count), 32'd1);
    step();

    // bubble and branch together: branch wins
    drive(1, 0, 0, 0, 0, 0, 1, 16'h4000);
    chk("bub_br", {load_pc, pc_redirect, load_if_id, flush_if_id}, 32'b1111);
    chk("bub_br_target", 32'(pc_target), 32'h4000);
    step();

    // reset while a redirect is pending
    drive(0, 1, 0, 0, 0, 0, 1, 16'h5555);
    step();
    reset = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_wait_outputs", {load_pc, load_if_id, pc_redirect, pc_target}, 32'h0);
    step();
    reset = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_wait_run", {pc_redirect, load_if_id, load_id_ex}, 32'b001);
    chk("rst_wait_counters", {dstall_count, flush_count}, 32'h0);
    step();

    // dstall counter wrap
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    for (int n = 0; n < 65535; n++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0);
      step();
    end
    drive(0, 0, 0, 1, 0, 0, 0, 16'h0);
    chk("dstall_ffff", 32'(dstall_count), 32'hFFFF);
    step();
    idle();
    chk("dstall_wrap", 32'(dstall_count), 32'h0);
    step();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
